// File: rtl/hangman_pkg.sv
// Shared types and default sizing for the parametrised hangman engine.
package hangman_pkg;

    localparam int DEF_WORD_LEN   = 5;
    localparam int DEF_LETTER_W   = 5;
    localparam int DEF_MAX_MISSES = 7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READY = 3'd1,
        ST_SCAN  = 3'd2,
        ST_EVAL  = 3'd3,
        ST_WON   = 3'd4,
        ST_LOST  = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        RES_NONE   = 2'b00,
        RES_HIT    = 2'b01,
        RES_MISS   = 2'b10,
        RES_REPEAT = 2'b11
    } result_e;

endpackage

// File: rtl/hangman_miss_tracker.sv
// Miss bookkeeping: one history bit per letter code plus a saturating miss
// counter. A letter already in the history is reported so the core can
// treat a repeated wrong guess as free.
module hangman_miss_tracker
    import hangman_pkg::*;
#(
    parameter int LETTER_W   = DEF_LETTER_W,
    parameter int MAX_MISSES = DEF_MAX_MISSES,
    parameter int MISS_W     = $clog2(MAX_MISSES + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear_i,
    input  logic [LETTER_W-1:0] test_letter_i,
    output logic                test_seen_o,
    input  logic                record_i,
    input  logic [LETTER_W-1:0] record_letter_i,
    output logic [MISS_W-1:0]   misses_o
);

    localparam int                HIST_N   = 1 << LETTER_W;
    localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(MAX_MISSES);

    logic [HIST_N-1:0] hist_q;
    logic [MISS_W-1:0] misses_q;

    // History and counter: cleared on reset or IDLE entry, updated on a recorded miss.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hist_q   <= '0;
            misses_q <= '0;
        end else if (clear_i) begin
            hist_q   <= '0;
            misses_q <= '0;
        end else if (record_i) begin
            hist_q[record_letter_i] <= 1'b1;
            if (misses_q != MISS_MAX) begin
                misses_q <= misses_q + MISS_W'(1);
            end
        end
    end

    assign test_seen_o = hist_q[test_letter_i];
    assign misses_o    = misses_q;

endmodule

// File: rtl/hangman_core_param.sv
// Blind-hangman engine. The guess is compared against one letter position
// per cycle; the verdict is formed during the last scan cycle so that it is
// registered and presented in EVAL together with the updated miss count.
module hangman_core_param
    import hangman_pkg::*;
#(
    parameter int WORD_LEN   = DEF_WORD_LEN,
    parameter int LETTER_W   = DEF_LETTER_W,
    parameter int MAX_MISSES = DEF_MAX_MISSES,
    parameter int MISS_W     = $clog2(MAX_MISSES + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         new_game,
    input  logic                         word_load,
    input  logic [WORD_LEN*LETTER_W-1:0] word_in,
    input  logic                         guess_valid,
    input  logic [LETTER_W-1:0]          guess_letter,
    output logic [WORD_LEN-1:0]          revealed,
    output logic [MISS_W-1:0]            misses,
    output logic                         busy,
    output logic                         result_valid,
    output logic [1:0]                   result_code,
    output logic                         game_won,
    output logic                         game_lost
);

    localparam int                  POS_W        = $clog2(WORD_LEN);
    localparam int                  WORD_W       = WORD_LEN * LETTER_W;
    localparam logic [POS_W-1:0]    LAST_POS     = POS_W'(WORD_LEN - 1);
    localparam logic [WORD_LEN-1:0] FIRST_BIT    = {1'b1, {(WORD_LEN-1){1'b0}}};
    localparam logic [WORD_LEN-1:0] ALL_REVEALED = '1;
    localparam logic [MISS_W-1:0]   MISS_LIMIT   = MISS_W'(MAX_MISSES);

    state_e              state_q;
    logic [WORD_W-1:0]   word_q;
    logic [LETTER_W-1:0] guess_q;
    logic [POS_W-1:0]    pos_q;
    logic                hit_q;
    logic                new_q;
    logic [WORD_LEN-1:0] revealed_q;
    logic                busy_q;
    logic                rv_q;
    result_e             rc_q;
    logic                won_q;
    logic                lost_q;

    logic [LETTER_W-1:0] cur_letter;
    logic [WORD_LEN-1:0] pos_mask;
    logic                match;
    logic                hit_d;
    logic                new_d;
    logic [WORD_LEN-1:0] revealed_d;
    logic                last_scan;
    logic                hist_seen;
    result_e             verdict_d;
    logic                record_miss;
    logic                tracker_clear;
    logic [MISS_W-1:0]   misses_w;
    logic                eval_won;
    logic                eval_lost;
    logic                guess_accept;

    // Current-position compare and the verdict it would produce if this is the last position.
    always_comb begin
        cur_letter = '0;
        for (int p = 0; p < WORD_LEN; p++) begin
            if (pos_q == POS_W'(p)) begin
                cur_letter = word_q[(WORD_LEN-1-p)*LETTER_W +: LETTER_W];
            end
        end
        pos_mask   = FIRST_BIT >> pos_q;
        match      = (cur_letter == guess_q);
        hit_d      = hit_q | match;
        new_d      = new_q | (match & ~|(revealed_q & pos_mask));
        revealed_d = match ? (revealed_q | pos_mask) : revealed_q;
        last_scan  = (state_q == ST_SCAN) && (pos_q == LAST_POS);
        if (hit_d) begin
            verdict_d = new_d ? RES_HIT : RES_REPEAT;
        end else begin
            verdict_d = hist_seen ? RES_REPEAT : RES_MISS;
        end
    end

    assign eval_won      = (revealed_q == ALL_REVEALED);
    assign eval_lost     = (misses_w == MISS_LIMIT);
    assign record_miss   = last_scan && !new_game && !hit_d && !hist_seen;
    assign tracker_clear = new_game || ((state_q == ST_IDLE) && word_load);
    assign guess_accept  = !new_game && guess_valid &&
                           ((state_q == ST_READY) ||
                            ((state_q == ST_EVAL) && !eval_won && !eval_lost));

    hangman_miss_tracker #(
        .LETTER_W   (LETTER_W),
        .MAX_MISSES (MAX_MISSES),
        .MISS_W     (MISS_W)
    ) u_tracker (
        .clk             (clk),
        .reset           (reset),
        .clear_i         (tracker_clear),
        .test_letter_i   (guess_q),
        .test_seen_o     (hist_seen),
        .record_i        (record_miss),
        .record_letter_i (guess_q),
        .misses_o        (misses_w)
    );

    // Word and guess holding registers: plain data, loaded only when accepted.
    always_ff @(posedge clk) begin
        if ((state_q == ST_IDLE) && word_load && !new_game) begin
            word_q <= word_in;
        end
        if (guess_accept) begin
            guess_q <= guess_letter;
        end
    end

    // Game FSM with registered status and verdict outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            pos_q      <= '0;
            hit_q      <= 1'b0;
            new_q      <= 1'b0;
            revealed_q <= '0;
            busy_q     <= 1'b0;
            rv_q       <= 1'b0;
            rc_q       <= RES_NONE;
            won_q      <= 1'b0;
            lost_q     <= 1'b0;
        end else begin
            rv_q <= 1'b0;
            rc_q <= RES_NONE;
            if (new_game) begin
                state_q    <= ST_IDLE;
                revealed_q <= '0;
                busy_q     <= 1'b0;
                won_q      <= 1'b0;
                lost_q     <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (word_load) begin
                            revealed_q <= '0;
                            state_q    <= ST_READY;
                        end
                    end
                    ST_READY: begin
                        if (guess_valid) begin
                            pos_q   <= '0;
                            hit_q   <= 1'b0;
                            new_q   <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= ST_SCAN;
                        end
                    end
                    ST_SCAN: begin
                        hit_q      <= hit_d;
                        new_q      <= new_d;
                        revealed_q <= revealed_d;
                        if (pos_q == LAST_POS) begin
                            state_q <= ST_EVAL;
                            rv_q    <= 1'b1;
                            rc_q    <= verdict_d;
                        end else begin
                            pos_q <= pos_q + POS_W'(1);
                        end
                    end
                    ST_EVAL: begin
                        if (eval_won) begin
                            busy_q  <= 1'b0;
                            won_q   <= 1'b1;
                            state_q <= ST_WON;
                        end else if (eval_lost) begin
                            busy_q  <= 1'b0;
                            lost_q  <= 1'b1;
                            state_q <= ST_LOST;
                        end else if (guess_valid) begin
                            pos_q   <= '0;
                            hit_q   <= 1'b0;
                            new_q   <= 1'b0;
                            state_q <= ST_SCAN;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= ST_READY;
                        end
                    end
                    default: begin
                        // WON and LOST hold until new_game or reset
                    end
                endcase
            end
        end
    end

    assign revealed     = revealed_q;
    assign misses       = misses_w;
    assign busy         = busy_q;
    assign result_valid = rv_q;
    assign result_code  = rc_q;
    assign game_won     = won_q;
    assign game_lost    = lost_q;

endmodule
